pc_source_select_reg: RTL



---
 rtl/pc_source_select_reg_if.sv | 30 +++
 rtl/pc_source_select_reg.sv | 108 ++++++++++
 2 files changed

// File: rtl/pc_source_select_reg_if.sv
// Bundle of the PC source-select datapath signals: candidate sources,
// select, load controls and the registered PC outputs.
interface pc_source_select_reg_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2
);
    logic [NUM_SRC*WIDTH-1:0] src;
    logic [SEL_W-1:0]         sel;
    logic                     pc_write;
    logic                     pc_write_cond;
    logic                     zero;
    logic                     stall;
    logic [WIDTH-1:0]         pc;
    logic [WIDTH-1:0]         pc_prev;
    logic                     redirect_pending;
    logic                     sel_err;

    // Control side: drives sources and load requests, observes the PC.
    modport master (
        output src, sel, pc_write, pc_write_cond, zero, stall,
        input  pc, pc_prev, redirect_pending, sel_err
    );

    // PC register side.
    modport slave (
        input  src, sel, pc_write, pc_write_cond, zero, stall,
        output pc, pc_prev, redirect_pending, sel_err
    );
endinterface

// File: rtl/pc_source_select_reg.sv
// N-way PC source select plus the PC register for the multicycle datapath.
// A load requested while stalled is parked in a one-entry pending slot
// (newest request wins) and applied on the first unstalled cycle unless a
// fresh load arrives in that cycle, which supersedes it.
module pc_source_select_reg #(
    parameter int               WIDTH      = 32,
    parameter int               NUM_SRC    = 4,
    parameter int               SEL_W      = 2,
    parameter logic [WIDTH-1:0] RESET_VEC  = {WIDTH{1'b0}},
    parameter int               ALIGN_BITS = 2
) (
    input  logic                   Clk,
    input  logic                   Rst,
    pc_source_select_reg_if.slave  bus
);

    // Low ALIGN_BITS cleared; ALIGN_BITS = 0 yields an all-ones mask.
    localparam logic [WIDTH-1:0] ALIGN_MASK =
        ~((WIDTH'(1) << ALIGN_BITS) - WIDTH'(1));
    localparam logic [SEL_W:0]   NUM_SRC_L  = (SEL_W+1)'(NUM_SRC);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] pc_q,       pc_d;
    logic [WIDTH-1:0] pc_prev_q,  pc_prev_d;
    logic [WIDTH-1:0] pend_val_q, pend_val_d;
    logic             sel_err_q,  sel_err_d;

    logic             load_s;
    logic             sel_bad_s;
    logic [WIDTH-1:0] raw_val_s;
    logic [WIDTH-1:0] sel_val_s;

    // Source mux: out-of-range selects fall back to source 0, then align.
    always_comb begin
        raw_val_s = bus.src[0 +: WIDTH];
        for (int i = 0; i < NUM_SRC; i++) begin
            raw_val_s = (bus.sel == SEL_W'(i)) ? bus.src[i*WIDTH +: WIDTH]
                                               : raw_val_s;
        end
        sel_bad_s = ({1'b0, bus.sel} >= NUM_SRC_L);
        sel_val_s = raw_val_s & ALIGN_MASK;
    end

    // Next-state: stall defers, fresh load beats pending, pending drains.
    always_comb begin
        load_s     = bus.pc_write | (bus.pc_write_cond & bus.zero);
        state_d    = state_q;
        pc_d       = pc_q;
        pc_prev_d  = pc_prev_q;
        pend_val_d = pend_val_q;
        sel_err_d  = load_s & sel_bad_s;

        if (bus.stall) begin
            if (load_s) begin
                pend_val_d = sel_val_s;
                state_d    = ST_PENDING;
            end else begin
                state_d    = state_q;
            end
        end else if (load_s) begin
            pc_d      = sel_val_s;
            pc_prev_d = pc_q;
            state_d   = ST_IDLE;
        end else begin
            case (state_q)
                ST_PENDING: begin
                    pc_d      = pend_val_q;
                    pc_prev_d = pc_q;
                    state_d   = ST_IDLE;
                end
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous reset taking priority over stall.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_VEC;
            pc_prev_q  <= RESET_VEC;
            pend_val_q <= {WIDTH{1'b0}};
            sel_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_prev_q  <= pc_prev_d;
            pend_val_q <= pend_val_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign bus.pc               = pc_q;
    assign bus.pc_prev          = pc_prev_q;
    assign bus.redirect_pending = (state_q == ST_PENDING);
    assign bus.sel_err          = sel_err_q;

endmodule
